mem_deskew: RTL
===============

MEM_DESKEW -- requirements
Module: mem_deskew

Interface
REQ-001 SHALL have parameter BITS_AB, default 8, meaning the signed element width.
REQ-002 SHALL have parameter DIM, default 8, meaning the number of lanes and rows (a power of 2, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: capture-stream advance qualifier.
REQ-006 SHALL have port Din, input, DIM x BITS_AB signed: the skewed diagonal stream, one element per lane.
REQ-007 SHALL have port RdEn, input, 1 bit: row read request.
REQ-008 SHALL have port Rrow, input, clog2(DIM) bits: the row to read.
REQ-009 SHALL have port Dout, output, DIM x BITS_AB signed: the deskewed row, registered.
REQ-010 SHALL have port Dvalid, output, 1 bit: Dout holds read data this cycle.
REQ-011 SHALL have port full, output, 1 bit: all DIM rows are captured and readable.
REQ-012 SHALL have port busy, output, 1 bit: capture is in progress.

Function
REQ-013 SHALL run the state machine IDLE -> CAPTURE -> FULL, with FULL -> CAPTURE on the first en cycle while in FULL.
REQ-014 SHALL move from IDLE to CAPTURE on the first cycle en=1, and SHALL treat that cycle as stream cycle t=0.
REQ-015 SHALL keep a cycle counter t, 0..2*DIM-2, that increments only on en=1 cycles in CAPTURE; en=0 stalls capture with no data loss.
REQ-016 SHALL, on each en cycle, write Din[c] to buf[t-c][c] for every lane c with 0 <= t-c <= DIM-1, and SHALL ignore lanes outside that window.
REQ-017 SHALL move to FULL after the en cycle at t=2*DIM-2, and SHALL assert full from the next cycle.
REQ-018 SHALL, on an en cycle while in FULL, restart capture at t=0 using that cycle's Din, and SHALL deassert full the same cycle; old rows are overwritten diagonally.
REQ-019 SHALL return buf[Rrow] on Dout with Dvalid=1 one cycle after RdEn=1, in any state; Dvalid=0 otherwise, and Dout holds its last value.
REQ-020 SHALL, when a read and a capture write hit the same element in the same cycle, return the old (pre-write) value.
REQ-021 SHALL not modify buffer contents on a read.
REQ-022 SHALL assert busy exactly while in CAPTURE.

Reset
REQ-023 SHALL, on rst=1, go to IDLE, set t=0, full=0, busy=0, Dvalid=0, Dout all zero, and clear every buf element to 0 on that edge.
REQ-024 SHALL, on rst during CAPTURE, abort the capture; a subsequent read returns zeros.
REQ-025 SHALL give rst priority over en and RdEn in the same cycle.

Configuration
REQ-026 SHALL, with MEM_DESKEW_OVERRUN_CHK_EN defined, add an output overrun that is sticky, set when en=1 arrives in FULL before every row has been read at least once since full rose, and cleared only by rst.
REQ-027 SHALL, without MEM_DESKEW_OVERRUN_CHK_EN, have no overrun port and no read-tracking logic; the rest of the behaviour is identical.

Structure
REQ-028 SHALL take BITS_AB/DIM default constants, the element typedef (signed BITS_AB), the row typedef (DIM elements) and the state enum {IDLE, CAPTURE, FULL} from the shared package systolic_pkg.
REQ-029 SHALL use one sub-module, deskew_lane: per-lane column storage with a window-compare write enable, instantiated DIM times.

Verification
REQ-030 SHALL cover reset clear: rst pulse, then read rows 0..7 -> every Dout element 0, Dvalid one cycle after each RdEn, full=0.
REQ-031 SHALL cover basic deskew: drive buf[r][c]=r*8+c skewed over 15 contiguous en cycles -> full=1 on cycle 16; reading row 3 returns 24..31.
REQ-032 SHALL cover a stall: the same data with en=0 inserted at t=4 and t=9 -> identical result; busy=1 throughout the stalls.
REQ-033 SHALL cover back-to-back capture: full=1, then a second stream of value -(r*8+c) -> full drops on its first en cycle; the final read of row 7 returns -56..-63.
REQ-034 SHALL cover read/write collision: in CAPTURE, read row 0 at t=3 -> the returned lane 3 holds the prior value, and lane 3 is updated afterwards.
REQ-035 SHALL cover the configured check (with MEM_DESKEW_OVERRUN_CHK_EN): restart when only rows 0..6 have been read -> overrun=1 and it stays 1 until rst.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants, element/row types and the capture FSM state for the systolic deskew buffer.
package systolic_pkg;

    localparam int unsigned DEF_BITS_AB = 8;
    localparam int unsigned DEF_DIM     = 8;

    typedef logic signed [DEF_BITS_AB-1:0] elem_t;
    typedef elem_t [DEF_DIM-1:0]           row_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        FULL
    } state_t;

endpackage

// File: rtl/deskew_lane.sv
// One column of the deskew buffer: stores lane LANE's element of every row,
// writing only while the stream cycle falls inside this lane's diagonal window.
module deskew_lane
    import systolic_pkg::*;
#(
    parameter int unsigned BITS_AB = DEF_BITS_AB,
    parameter int unsigned DIM     = DEF_DIM,
    parameter int unsigned LANE    = 0,
    parameter int unsigned TW      = $clog2(2*DIM-1),
    parameter int unsigned RW      = $clog2(DIM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [TW-1:0]      t_i,
    input  logic [BITS_AB-1:0] din_i,
    input  logic [RW-1:0]      rrow_i,
    output logic [BITS_AB-1:0] rdata_c_o
);

    logic [BITS_AB-1:0] col_q [DIM];
    logic               wr_hit_c;
    logic [RW-1:0]      wrow_c;

    // Row written at stream cycle t is t-LANE, valid only for 0 <= t-LANE <= DIM-1.
    always_comb begin
        wr_hit_c = wr_en_i && (32'(t_i) >= LANE) && (32'(t_i) < LANE + DIM);
        wrow_c   = RW'(32'(t_i) - LANE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DIM); i++) begin
                col_q[i] <= '0;
            end
        end else if (wr_hit_c) begin
            col_q[wrow_c] <= din_i;
        end
    end

    assign rdata_c_o = col_q[rrow_i];

endmodule

// File: rtl/mem_deskew.sv
// Captures a skewed diagonal stream into a DIM x DIM buffer and reads back deskewed rows.
// Optional sticky overrun flag (unread rows overwritten) enabled by MEM_DESKEW_OVERRUN_CHK_EN.
module mem_deskew
    import systolic_pkg::*;
#(
    parameter int unsigned BITS_AB = DEF_BITS_AB,
    parameter int unsigned DIM     = DEF_DIM
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic signed [DIM-1:0][BITS_AB-1:0] Din,
    input  logic                              RdEn,
    input  logic [$clog2(DIM)-1:0]            Rrow,
    output logic signed [DIM-1:0][BITS_AB-1:0] Dout,
    output logic                              Dvalid,
    output logic                              full,
    output logic                              busy
`ifdef MEM_DESKEW_OVERRUN_CHK_EN
    ,
    output logic                              overrun
`endif
);

    localparam int unsigned TW     = $clog2(2*DIM-1);
    localparam logic [TW-1:0] T_LAST = TW'(2*DIM-2);

    state_t                    state_q, state_d;
    logic [TW-1:0]             t_q, t_d, t_eff_c;
    logic                      full_d, busy_d;
    logic                      full_q, busy_q, dvalid_q;
    logic [DIM-1:0][BITS_AB-1:0] rd_row_c, dout_q;

    // Any en outside CAPTURE starts a fresh stream, so its write uses t=0.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        t_eff_c = '0;
        case (state_q)
            IDLE, FULL: begin
                if (en) begin
                    state_d = CAPTURE;
                    t_d     = TW'(1);
                end
            end
            CAPTURE: begin
                t_eff_c = t_q;
                if (en) begin
                    if (t_q == T_LAST) begin
                        state_d = FULL;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        full_d = (state_d == FULL);
        busy_d = (state_d == CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= 1'b0;
            busy_q   <= 1'b0;
            dvalid_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            full_q   <= full_d;
            busy_q   <= busy_d;
            dvalid_q <= RdEn;
            if (RdEn) begin
                dout_q <= rd_row_c;
            end
        end
    end

    for (genvar c = 0; c < int'(DIM); c++) begin : g_lane
        deskew_lane #(
            .BITS_AB (BITS_AB),
            .DIM     (DIM),
            .LANE    (c),
            .TW      (TW)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (en),
            .t_i       (t_eff_c),
            .din_i     (Din[c]),
            .rrow_i    (Rrow),
            .rdata_c_o (rd_row_c[c])
        );
    end

    assign Dout   = dout_q;
    assign Dvalid = dvalid_q;
    assign full   = full_q;
    assign busy   = busy_q;

`ifdef MEM_DESKEW_OVERRUN_CHK_EN
    logic [DIM-1:0] rd_seen_q;
    logic           overrun_q;

    // Read tracking restarts whenever the buffer is not full.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_seen_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (state_q != FULL) begin
                rd_seen_q <= '0;
            end else if (RdEn) begin
                rd_seen_q[Rrow] <= 1'b1;
            end
            if ((state_q == FULL) && en && !(&rd_seen_q)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign overrun = overrun_q;
`endif

endmodule
